// File: rtl/uart_tx.sv
// uart_tx: UART transmitter, 8 data bits LSB first, 1 stop bit, fed by a small byte FIFO.
// Frames are sent back-to-back with no idle gap while the FIFO holds data.
// Build option: define UART_TX_PARITY_EN to insert one even-parity bit after D7 (11-bit frame).
module uart_tx #(
    parameter int CLK_HZ       = 12000000,
    parameter int BAUD         = 115200,
    parameter int CLKS_PER_BIT = CLK_HZ / BAUD,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       tx,
    output logic       busy
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] BIT_LAST   = CW'(CLKS_PER_BIT - 1);
    localparam logic [PW:0]   COUNT_FULL = (PW+1)'(FIFO_DEPTH);

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;
`else
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd3
    } state_t;
`endif

    logic [7:0]    mem [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [PW:0]   count;
    logic [7:0]    head;
    logic          push;
    logic          pop;
    logic          bit_done;

    state_t        state;
    logic [CW-1:0] baud_cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    shift;
`ifdef UART_TX_PARITY_EN
    logic          parity;
`endif

    // Readiness comes from the registered count only, so a same-cycle pop
    // never lets a push into a full FIFO.
    assign tx_ready = (count != COUNT_FULL);
    assign push     = tx_valid && tx_ready;
    assign head     = mem[rd_ptr];
    assign bit_done = (baud_cnt == BIT_LAST);
    assign busy     = (state != IDLE) || (count != '0);

    // Pop whenever the line is free to start a frame: from IDLE, or at the
    // very last cycle of the stop bit so the next start bit follows directly.
    always_comb begin
        pop = 1'b0;
        if (count != '0) begin
            if (state == IDLE)
                pop = 1'b1;
            else if (state == STOP && bit_done)
                pop = 1'b1;
        end
    end

    // FIFO storage; contents need no reset since count gates every read.
    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= tx_data;
    end

    // FIFO pointers and occupancy; push and pop together leave count unchanged.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + PW'(1);
            if (pop)
                rd_ptr <= rd_ptr + PW'(1);
            case ({push, pop})
                2'b10:   count <= count + (PW+1)'(1);
                2'b01:   count <= count - (PW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    // Frame sequencer: baud timing, bit shifting and the registered tx line.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            tx       <= 1'b1;
            baud_cnt <= '0;
            bit_idx  <= '0;
            shift    <= '0;
`ifdef UART_TX_PARITY_EN
            parity   <= 1'b0;
`endif
        end else begin
            baud_cnt <= bit_done ? '0 : baud_cnt + CW'(1);
            case (state)
                IDLE: begin
                    baud_cnt <= '0;
                    tx       <= 1'b1;
                    if (pop) begin
                        shift   <= head;
`ifdef UART_TX_PARITY_EN
                        parity  <= ^head;
`endif
                        bit_idx <= '0;
                        tx      <= 1'b0;
                        state   <= START;
                    end
                end
                START: begin
                    if (bit_done) begin
                        tx      <= shift[0];
                        bit_idx <= '0;
                        state   <= DATA;
                    end
                end
                DATA: begin
                    if (bit_done) begin
                        if (bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                            tx    <= parity;
                            state <= PARITY;
`else
                            tx    <= 1'b1;
                            state <= STOP;
`endif
                        end else begin
                            tx      <= shift[1];
                            shift   <= {1'b0, shift[7:1]};
                            bit_idx <= bit_idx + 3'd1;
                        end
                    end
                end
`ifdef UART_TX_PARITY_EN
                PARITY: begin
                    if (bit_done) begin
                        tx    <= 1'b1;
                        state <= STOP;
                    end
                end
`endif
                STOP: begin
                    if (bit_done) begin
                        if (pop) begin
                            shift   <= head;
`ifdef UART_TX_PARITY_EN
                            parity  <= ^head;
`endif
                            bit_idx <= '0;
                            tx      <= 1'b0;
                            state   <= START;
                        end else begin
                            tx    <= 1'b1;
                            state <= IDLE;
                        end
                    end
                end
                default: begin
                    tx    <= 1'b1;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: frame-level reference model compared every cycle, a
// mid-bit sampling receiver, and literal checks of key timing points.
module tb_uart_tx;

    localparam int CPB   = 12000000 / 115200;
    localparam int DEPTH = 4;
`ifdef UART_TX_PARITY_EN
    localparam int NBITS = 11;
`else
    localparam int NBITS = 10;
`endif
    localparam int FL = NBITS * CPB;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_ready;
    logic       tx;
    logic       busy;

    uart_tx dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .tx       (tx),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp)
            n_pass++;
        else
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // ---------------- reference model: frame position arithmetic ----------------
    logic [7:0] mq[$];        // bytes waiting in the FIFO
    logic [7:0] exp_rx[$];    // bytes the line must carry, in order
    bit         m_active = 0;
    int         m_pos = 0;    // cycle index inside the current frame
    logic [7:0] m_byte = 8'h00;
    bit         m_acc;
    bit         m_pop;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mq.delete();
            exp_rx.delete();
            m_active = 0;
            m_pos    = 0;
        end else begin
            m_acc = tx_valid && (mq.size() < DEPTH);
            m_pop = (mq.size() > 0) && (!m_active || m_pos == FL - 1);
            if (m_active) begin
                m_pos++;
                if (m_pos == FL) m_active = 0;
            end
            if (m_pop) begin
                m_byte = mq.pop_front();
                exp_rx.push_back(m_byte);
                m_active = 1;
                m_pos    = 0;
            end
            if (m_acc) mq.push_back(tx_data);
        end
    end

    function automatic logic exp_line();
        int b;
        if (!m_active) return 1'b1;
        b = m_pos / CPB;
        if (b == 0) return 1'b0;
        if (b <= 8) return m_byte[b-1];
`ifdef UART_TX_PARITY_EN
        if (b == 9) return ^m_byte;
`endif
        return 1'b1;
    endfunction

    // Single compare process: outputs against the model every cycle.
    always @(negedge clk) begin
        chk("cycle{tx,ready,busy}", {29'd0, tx, tx_ready, busy},
            {29'd0, exp_line(), (mq.size() < DEPTH), (m_active || mq.size() > 0)});
    end

    // ---------------- bench receiver, samples mid-bit ----------------
    logic [7:0] rx_log[$];
    bit         r_act = 0;
    int         r_cnt = 0;
    logic [7:0] r_byte = 8'h00;
    logic [7:0] r_exp;

    always @(negedge clk) begin
        if (!rst_n) begin
            r_act = 0;
        end else if (!r_act) begin
            if (tx === 1'b0) begin
                r_act = 1;
                r_cnt = 0;
            end
        end else begin
            r_cnt++;
            if (r_cnt % CPB == CPB / 2) begin
                if (r_cnt / CPB == 0) begin
                    chk("rx_start_bit", {31'd0, tx}, 32'd0);
                end else if (r_cnt / CPB <= 8) begin
                    r_byte[r_cnt/CPB-1] = tx;
`ifdef UART_TX_PARITY_EN
                end else if (r_cnt / CPB == 9) begin
                    chk("rx_parity_bit", {31'd0, tx}, {31'd0, ^r_byte});
`endif
                end else begin
                    chk("rx_stop_bit", {31'd0, tx}, 32'd1);
                    rx_log.push_back(r_byte);
                    if (exp_rx.size() == 0) begin
                        n_total++;
                        $display("FAIL rx_byte: got %0h expected none at %0t", r_byte, $time);
                    end else begin
                        r_exp = exp_rx.pop_front();
                        chk("rx_byte", {24'd0, r_byte}, {24'd0, r_exp});
                    end
                    r_act = 0;
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic drain(input string name);
        int n = 0;
        while ((m_active || mq.size() > 0) && n < 8 * FL) begin
            @(negedge clk);
            n++;
        end
        chk({name, "_drain_in_time"}, {31'd0, (n < 8 * FL)}, 32'd1);
        repeat (CPB) @(negedge clk);
        chk({name, "_all_received"}, exp_rx.size(), 32'd0);
    endtask

    task automatic push_one(input logic [7:0] b);
        @(negedge clk);
        #1;
        tx_valid = 1'b1;
        tx_data  = b;
        @(negedge clk);
        #1;
        tx_valid = 1'b0;
        tx_data  = 8'($urandom);
    endtask

    task automatic chk_log(input string name, input logic [7:0] exp_q[$]);
        chk({name, "_count"}, rx_log.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < rx_log.size(); i++)
            chk(name, {24'd0, rx_log[i]}, {24'd0, exp_q[i]});
    endtask

`ifdef UART_TX_PARITY_EN
    task automatic parity_probe(input logic [7:0] b, input logic pbit);
        push_one(b);          // now just after accept edge + 1 (m = 0)
        for (int m = 1; m <= FL; m++) begin
            @(negedge clk);
            if (m == 9 * CPB + CPB / 2) chk("parity_bit", {31'd0, tx}, {31'd0, pbit});
            if (m == 1143) chk("parity_busy_last", {31'd0, busy}, 32'd1);
            if (m == 1144) chk("parity_busy_end", {31'd0, busy}, 32'd0);
        end
        drain("parity");
    endtask
`endif

    logic [7:0] exp_bytes[$];
    int         pat55[11];
    int         bounded;

    initial begin
        repeat (200000) @(posedge clk);
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // reset state
        repeat (3) @(negedge clk);
        chk("reset_tx", {31'd0, tx}, 32'd1);
        chk("reset_ready", {31'd0, tx_ready}, 32'd1);
        chk("reset_busy", {31'd0, busy}, 32'd0);
        #2 rst_n = 1'b1;
        repeat (5) @(negedge clk);

        // single 0x55: start one cycle after accept, then 0,1,0,1,... mid-bit
`ifdef UART_TX_PARITY_EN
        pat55 = '{0, 1, 0, 1, 0, 1, 0, 1, 0, 0, 1};
`else
        pat55 = '{0, 1, 0, 1, 0, 1, 0, 1, 0, 1, 1};
`endif
        #1;
        tx_valid = 1'b1;
        tx_data  = 8'h55;
        @(negedge clk);           // after accept edge
        #1 tx_valid = 1'b0;
        chk("latency_tx_still_high", {31'd0, tx}, 32'd1);
        chk("busy_after_accept", {31'd0, busy}, 32'd1);
        @(negedge clk);           // after pop edge: m = 0
        chk("latency_tx_fell", {31'd0, tx}, 32'd0);
        for (int m = 1; m <= FL; m++) begin
            @(negedge clk);
            if (m % CPB == CPB / 2) chk("bits_0x55", {31'd0, tx}, pat55[m / CPB]);
            if (m == FL - 1) chk("busy_last_stop_cycle", {31'd0, busy}, 32'd1);
            if (m == FL) chk("busy_dropped", {31'd0, busy}, 32'd0);
        end
        drain("single");

        // five back-to-back pushes: FIFO fills on the fifth
        rx_log.delete();
        @(negedge clk);
        #1;
        exp_bytes = '{8'hFF, 8'h00, 8'h11, 8'h01, 8'h5A};
        for (int i = 0; i < 5; i++) begin
            tx_valid = 1'b1;
            tx_data  = exp_bytes[i];
            @(negedge clk);
            #1;
            if (i == 3) chk("ready_after_4th", {31'd0, tx_ready}, 32'd1);
            if (i == 4) chk("ready_low_full", {31'd0, tx_ready}, 32'd0);
        end
        tx_valid = 1'b0;
        drain("queue");
        chk_log("queue_order", exp_bytes);

        // hold valid with incrementing data: only 0x30..0x34 fit
        rx_log.delete();
        @(negedge clk);
        #1;
        for (int i = 0; i < 8; i++) begin
            tx_valid = 1'b1;
            tx_data  = 8'h30 + 8'(i);
            @(negedge clk);
            #1;
        end
        tx_valid = 1'b0;
        drain("full");
        exp_bytes = '{8'h30, 8'h31, 8'h32, 8'h33, 8'h34};
        chk_log("full_order", exp_bytes);

        // simultaneous push and pop on the stop-bit expiry
        rx_log.delete();
        push_one(8'h81);
        repeat (100) @(negedge clk);
        push_one(8'h42);
        bounded = 0;
        while (!(m_active && m_pos == FL - 1 && mq.size() == 1) && bounded < 2 * FL) begin
            @(negedge clk);
            bounded++;
        end
        chk("simul_reached_expiry", {31'd0, (bounded < 2 * FL)}, 32'd1);
        #1;
        tx_valid = 1'b1;
        tx_data  = 8'hE7;
        @(negedge clk);
        #1 tx_valid = 1'b0;
        chk("simul_next_start", {31'd0, tx}, 32'd0);
        chk("simul_ready", {31'd0, tx_ready}, 32'd1);
        drain("simul");
        exp_bytes = '{8'h81, 8'h42, 8'hE7};
        chk_log("simul_order", exp_bytes);

`ifdef UART_TX_PARITY_EN
        parity_probe(8'h03, 1'b0);
        parity_probe(8'h07, 1'b1);
`endif

        // randomized bursts
        for (int it = 0; it < 10; it++) begin
            repeat ($urandom_range(0, 600)) @(negedge clk);
            #1;
            for (int j = 0; j < int'($urandom_range(1, 3)); j++) begin
                tx_valid = ($urandom_range(0, 3) != 0);
                tx_data  = 8'($urandom);
                @(negedge clk);
                #1;
            end
            tx_valid = 1'b0;
        end
        drain("random");

        // reset during D3 of 0xA5 with two bytes queued
        rx_log.delete();
        @(negedge clk);
        #1;
        tx_valid = 1'b1;
        tx_data  = 8'hA5;
        @(negedge clk);
        #1 tx_data = 8'hC3;
        @(negedge clk);           // m = 0
        #1 tx_data = 8'h3C;
        @(negedge clk);           // m = 1
        #1 tx_valid = 1'b0;
        repeat (4 * CPB + CPB / 2 - 1) @(negedge clk);
        chk("pre_reset_d3_low", {31'd0, tx}, 32'd0);
        #2 rst_n = 1'b0;
        #1;
        chk("reset_async_tx", {31'd0, tx}, 32'd1);
        chk("reset_async_ready", {31'd0, tx_ready}, 32'd1);
        chk("reset_async_busy", {31'd0, busy}, 32'd0);
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b1;
        repeat (3 * FL) @(negedge clk);
        chk("post_reset_tx", {31'd0, tx}, 32'd1);
        chk("post_reset_busy", {31'd0, busy}, 32'd0);
        chk("post_reset_ready", {31'd0, tx_ready}, 32'd1);
        chk("post_reset_no_frames", rx_log.size(), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
